// File: rtl/core_dmem_axil_if.sv
// ----------------------------------------------------------------------------
// core_dmem_axil_if
// Purpose : AXI4-Lite bundle between the core HOST_AXI master and the data
//           memory slave. Signal names follow the AXI_* port names of the
//           data-memory block.
// Modports: master - drives AW/W/AR channels and BREADY/RREADY
//           slave  - drives AWREADY/WREADY/ARREADY and the B/R channels
// Params  : AXI_AWIDTH - address width of AW/AR channels
//           AXI_DWIDTH - data width (32), WSTRB is AXI_DWIDTH/8
// ----------------------------------------------------------------------------
interface core_dmem_axil_if #(
  parameter int unsigned AXI_AWIDTH = 32,
  parameter int unsigned AXI_DWIDTH = 32
);
  localparam int unsigned STRB_W = AXI_DWIDTH / 8;

  // write address channel
  logic [AXI_AWIDTH-1:0] AXI_AWADDR;
  logic                  AXI_AWVALID;
  logic                  AXI_AWREADY;
  // write data channel
  logic [AXI_DWIDTH-1:0] AXI_WDATA;
  logic [STRB_W-1:0]     AXI_WSTRB;
  logic                  AXI_WVALID;
  logic                  AXI_WREADY;
  // write response channel
  logic [1:0]            AXI_BRESP;
  logic                  AXI_BVALID;
  logic                  AXI_BREADY;
  // read address channel
  logic [AXI_AWIDTH-1:0] AXI_ARADDR;
  logic                  AXI_ARVALID;
  logic                  AXI_ARREADY;
  // read data channel
  logic [AXI_DWIDTH-1:0] AXI_RDATA;
  logic [1:0]            AXI_RRESP;
  logic                  AXI_RVALID;
  logic                  AXI_RREADY;

  modport master (
    output AXI_AWADDR, AXI_AWVALID,
    input  AXI_AWREADY,
    output AXI_WDATA, AXI_WSTRB, AXI_WVALID,
    input  AXI_WREADY,
    input  AXI_BRESP, AXI_BVALID,
    output AXI_BREADY,
    output AXI_ARADDR, AXI_ARVALID,
    input  AXI_ARREADY,
    input  AXI_RDATA, AXI_RRESP, AXI_RVALID,
    output AXI_RREADY
  );

  modport slave (
    input  AXI_AWADDR, AXI_AWVALID,
    output AXI_AWREADY,
    input  AXI_WDATA, AXI_WSTRB, AXI_WVALID,
    output AXI_WREADY,
    output AXI_BRESP, AXI_BVALID,
    input  AXI_BREADY,
    input  AXI_ARADDR, AXI_ARVALID,
    output AXI_ARREADY,
    output AXI_RDATA, AXI_RRESP, AXI_RVALID,
    input  AXI_RREADY
  );

endinterface

// File: rtl/core_dmem_axil.sv
// ----------------------------------------------------------------------------
// core_dmem_axil
// Purpose : AXI4-Lite data-memory slave for the core HOST_AXI port. Word
//           array of MEM_DEPTH x 32 bit with independent read and write FSMs.
//           Write accepts AW and W in any order, commits byte lanes when both
//           are held, then holds B until BREADY. Read latches AR, reads the
//           array one cycle later and holds R until RREADY (read-before-write
//           on a same-edge collision).
// Ports   : CLK   - clock, rising edge
//           RST   - synchronous active-high reset (array not cleared)
//           s_axi - core_dmem_axil_if.slave AXI4-Lite bundle
// Config  : `define DMEM_RANGE_CHECK_EN to answer addresses outside
//           [BASE_ADDR, BASE_ADDR + 4*MEM_DEPTH) with SLVERR (write dropped,
//           RDATA = 0). Without it the word index simply wraps.
// ----------------------------------------------------------------------------
module core_dmem_axil #(
  parameter int unsigned           AXI_AWIDTH = 32,
  parameter int unsigned           AXI_DWIDTH = 32,
  parameter int unsigned           MEM_DEPTH  = 1024,
  parameter logic [AXI_AWIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic             CLK,
  input  logic             RST,
  core_dmem_axil_if.slave  s_axi
);

  localparam int unsigned STRB_W      = AXI_DWIDTH / 8;
  localparam int unsigned IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_DATA} rstate_e;

  // Word index: byte offset from BASE_ADDR, low two bits dropped, wrapped.
  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_AWIDTH-1:0] addr);
    logic [AXI_AWIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

`ifdef DMEM_RANGE_CHECK_EN
  // In window when at/above base and the offset fits in the array span.
  function automatic logic addr_in_range(input logic [AXI_AWIDTH-1:0] addr);
    logic [AXI_AWIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((off >> (IDX_W + 2)) == '0);
  endfunction
`endif

  logic [AXI_DWIDTH-1:0] mem_q [MEM_DEPTH];

  // ---------------------------------------------------------------- write path
  wstate_e               wstate_q, wstate_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [AXI_AWIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_DWIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  aw_hs, w_hs, have_aw, have_w, wr_fire, wr_ok, mem_we;
  logic [AXI_AWIDTH-1:0] wr_addr;
  logic [AXI_DWIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx;

  assign aw_hs   = s_axi.AXI_AWVALID & awready_q;
  assign w_hs    = s_axi.AXI_WVALID & wready_q;
  assign have_aw = aw_held_q | aw_hs;
  assign have_w  = w_held_q | w_hs;
  assign wr_fire = (wstate_q == W_IDLE) & have_aw & have_w;

  // Commit uses the latched beat if present, otherwise the one on the bus now.
  assign wr_addr = aw_held_q ? awaddr_q : s_axi.AXI_AWADDR;
  assign wr_data = w_held_q  ? wdata_q  : s_axi.AXI_WDATA;
  assign wr_strb = w_held_q  ? wstrb_q  : s_axi.AXI_WSTRB;
  assign wr_idx  = word_idx(wr_addr);
`ifdef DMEM_RANGE_CHECK_EN
  assign wr_ok   = addr_in_range(wr_addr);
`else
  assign wr_ok   = 1'b1;
`endif
  // A commit coinciding with reset is aborted.
  assign mem_we  = wr_fire & wr_ok & ~RST;

  // Write FSM state register
  always_ff @(posedge CLK) begin
    if (RST) wstate_q <= W_IDLE;
    else     wstate_q <= wstate_d;
  end

  // Write FSM next state
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (wr_fire) wstate_d = W_RESP;
      W_RESP:  if (s_axi.AXI_BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write FSM outputs and beat latches (next values)
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) awaddr_d = s_axi.AXI_AWADDR;
    if (w_hs) begin
      wdata_d = s_axi.AXI_WDATA;
      wstrb_d = s_axi.AXI_WSTRB;
    end
    case (wstate_q)
      W_IDLE: begin
        aw_held_d = have_aw;
        w_held_d  = have_w;
        if (wr_fire) begin
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
          // Each channel stays ready only until its own beat is captured.
          awready_d = ~have_aw;
          wready_d  = ~have_w;
        end
      end
      W_RESP: begin
        if (s_axi.AXI_BREADY) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Write path registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Byte-lane write into the array; no reset so contents survive RST.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < int'(STRB_W); i++) begin
        if (wr_strb[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read path
  rstate_e               rstate_q, rstate_d;
  logic [AXI_AWIDTH-1:0] araddr_q, araddr_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [AXI_DWIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  ar_hs, rd_ok;
  logic [IDX_W-1:0]      rd_idx;

  assign ar_hs  = s_axi.AXI_ARVALID & arready_q;
  assign rd_idx = word_idx(araddr_q);
`ifdef DMEM_RANGE_CHECK_EN
  assign rd_ok  = addr_in_range(araddr_q);
`else
  assign rd_ok  = 1'b1;
`endif

  // Read FSM state register
  always_ff @(posedge CLK) begin
    if (RST) rstate_q <= R_IDLE;
    else     rstate_q <= rstate_d;
  end

  // Read FSM next state
  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:   if (ar_hs) rstate_d = R_ACCESS;
      R_ACCESS: rstate_d = R_DATA;
      R_DATA:   if (s_axi.AXI_RREADY) rstate_d = R_IDLE;
      default:  rstate_d = R_IDLE;
    endcase
  end

  // Read FSM outputs; array sampled on the R_ACCESS edge, so a same-edge
  // write commit is not yet visible (read-before-write).
  always_comb begin
    araddr_d  = araddr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_hs) araddr_d = s_axi.AXI_ARADDR;
    case (rstate_q)
      R_IDLE: arready_d = ~ar_hs;
      R_ACCESS: begin
        rvalid_d = 1'b1;
        rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
        rdata_d  = rd_ok ? mem_q[rd_idx] : '0;
      end
      R_DATA: begin
        if (s_axi.AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Read path registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      araddr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      araddr_q  <= araddr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Bus outputs straight from registers
  assign s_axi.AXI_AWREADY = awready_q;
  assign s_axi.AXI_WREADY  = wready_q;
  assign s_axi.AXI_BVALID  = bvalid_q;
  assign s_axi.AXI_BRESP   = bresp_q;
  assign s_axi.AXI_ARREADY = arready_q;
  assign s_axi.AXI_RVALID  = rvalid_q;
  assign s_axi.AXI_RDATA   = rdata_q;
  assign s_axi.AXI_RRESP   = rresp_q;

endmodule

// File: doc/core_dmem_axil.md
CORE_DMEM_AXIL -- requirements
Module: core_dmem_axil

Interface
REQ-001 Parameter AXI_AWIDTH, default 32: address width of all AXI4-Lite address channels.
REQ-002 Parameter AXI_DWIDTH, default 32: data width; fixed at 32; WSTRB width is AXI_DWIDTH/8.
REQ-003 Parameter MEM_DEPTH, default 1024: number of 32-bit words; power of two.
REQ-004 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-005 CLK  in  1  sole clock; all logic on its rising edge.
REQ-006 RST  in  1  synchronous, active-high reset.
REQ-007 AXI_AWADDR in AXI_AWIDTH, AXI_AWVALID in 1, AXI_AWREADY out 1: write address channel.
REQ-008 AXI_WDATA in 32, AXI_WSTRB in 4, AXI_WVALID in 1, AXI_WREADY out 1: write data channel.
REQ-009 AXI_BRESP out 2, AXI_BVALID out 1, AXI_BREADY in 1: write response channel.
REQ-010 AXI_ARADDR in AXI_AWIDTH, AXI_ARVALID in 1, AXI_ARREADY out 1: read address channel.
REQ-011 AXI_RDATA out 32, AXI_RRESP out 2, AXI_RVALID out 1, AXI_RREADY in 1: read data channel.

Function
REQ-012 Block is the AXI4-Lite data-memory slave served by the core's HOST_AXI master port; read and write paths are independent FSMs sharing one word array.
REQ-013 Word index = (ADDR - BASE_ADDR) >> 2, truncated to log2(MEM_DEPTH) bits; ADDR[1:0] ignored.
REQ-014 Write FSM states: W_IDLE, W_RESP.
REQ-015 In W_IDLE, AWREADY=1 while no address latched and WREADY=1 while no data latched; AW and W accepted in either order or in the same cycle.
REQ-016 On the edge where both address and data are held (or handshaked), write byte lanes i where WSTRB[i]=1, set BVALID=1 and BRESP, enter W_RESP.
REQ-017 In W_RESP, AWREADY=WREADY=0; BVALID and BRESP held stable until BREADY=1; on BVALID&BREADY, clear latches and return to W_IDLE next cycle.
REQ-018 WSTRB=4'b0000 completes the handshake with BRESP=OKAY and no array change.
REQ-019 Read FSM states: R_IDLE, R_ACCESS, R_DATA.
REQ-020 R_IDLE: ARREADY=1; AR handshake in cycle N latches address, enters R_ACCESS; RVALID=1 with data in cycle N+2.
REQ-021 R_DATA: ARREADY=0; RDATA/RRESP held stable until RREADY=1; on RVALID&RREADY return to R_IDLE (next AR accepted the following cycle).
REQ-022 Same-word read access and write commit in the same cycle: read returns pre-write data (read-before-write).
REQ-023 RRESP and BRESP are OKAY (2'b00) unless REQ-028 applies.
REQ-024 No outstanding-transaction queue: at most one read and one write in flight.

Reset
REQ-025 On RST=1 at a clock edge: AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0; FSMs to W_IDLE/R_IDLE; latched AW/W/AR discarded.
REQ-026 Reset mid-transaction aborts it; a write not yet committed does not reach the array; array contents are not cleared by reset.
REQ-027 Ready outputs rise the first cycle after RST deasserts.

Configuration
REQ-028 Macro DMEM_RANGE_CHECK_EN: when defined, address below BASE_ADDR or at/above BASE_ADDR+4*MEM_DEPTH yields SLVERR (2'b10); write suppressed, RDATA=0; handshake timing unchanged.
REQ-029 Without DMEM_RANGE_CHECK_EN: no range check, index wraps per REQ-013, responses always OKAY.

Verification
REQ-030 AW=0x10 and W=0xDEADBEEF/4'hF same cycle, BREADY=1 -> BVALID 1 cycle later, BRESP=0; read 0x10 -> RDATA=0xDEADBEEF, RVALID 2 cycles after AR handshake.
REQ-031 W 0x000000AA/4'b0001 three cycles before AW=0x10 -> write on AW handshake; read 0x10 -> 0xDEADBEAA.
REQ-032 BREADY held 0 for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout; RREADY held 0 -> RDATA stable, ARREADY=0.
REQ-033 Read and write to 0x20 (old 0x11111111, new 0x22222222) committing same cycle -> RDATA=0x11111111; later read -> 0x22222222.
REQ-034 RST asserted with AW latched and W pending -> all valids/readies 0 next cycle; word unchanged afterwards.
REQ-035 With DMEM_RANGE_CHECK_EN, MEM_DEPTH=1024: write 0x1000 -> BRESP=2'b10, word 0 unchanged; read 0x1000 -> RRESP=2'b10, RDATA=0. Without macro: write to 0x1000 lands in word 0, BRESP=0.
